// File: rtl/rom_loader_if.sv
// Host-link and program-memory signal bundle for rom_loader.
// master: host/bench side (drives the byte stream, observes memory and status).
// slave : loader side.
interface rom_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_run;
   logic       load_err;
   logic       busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err, busy
   );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: receives a framed byte stream (START, LEN, payload[, CSUM]),
// writes the payload into program memory from address 0 and releases the CPU
// once a complete frame has been loaded.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte (8-bit sum of payload). Without it a frame completes after the
// last payload byte and load_err stays 0.
module rom_loader #(
   parameter logic [7:0] START_BYTE = 8'hA5
) (
   input  logic         clk,
   input  logic         reset,
   rom_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   state_t     r_state;
   logic [8:0] r_count;     // remaining payload bytes, 1..256
   logic [7:0] r_addr;
   logic [7:0] r_csum;
   logic       r_we;
   logic [7:0] r_waddr;
   logic [7:0] r_wdata;
   logic       r_cpu_run;
   logic       r_load_err;

   logic       w_accept;
   logic       w_start;
   logic       w_last;
   logic [7:0] w_csum_next;

   // A byte is only taken in cycles without a pending memory write.
   assign w_accept    = bus.in_valid & ~r_we;
   assign w_start     = (bus.in_data == START_BYTE);
   assign w_last      = (r_count == 9'd1);
   assign w_csum_next = r_csum + bus.in_data;

   // Frame parser, address/checksum counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_addr     <= '0;
         r_csum     <= '0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_cpu_run  <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_accept) begin
            case (r_state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (w_start) begin
                     r_state    <= S_LEN;
                     r_cpu_run  <= 1'b0;
                     r_load_err <= 1'b0;
                     r_csum     <= '0;
                  end
               end
               S_LEN: begin
                  r_count <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                  r_addr  <= '0;
                  r_state <= S_DATA;
               end
               S_DATA: begin
                  r_we    <= 1'b1;
                  r_waddr <= r_addr;
                  r_wdata <= bus.in_data;
                  r_addr  <= r_addr + 8'd1;
                  r_csum  <= w_csum_next;
                  r_count <= r_count - 9'd1;
                  if (w_last) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                     r_state <= S_CSUM;
`else
                     r_state   <= S_DONE;
                     r_cpu_run <= 1'b1;
`endif
                  end
               end
`ifdef ROM_LOADER_CHECKSUM_EN
               S_CSUM: begin
                  if (bus.in_data == r_csum) begin
                     r_state   <= S_DONE;
                     r_cpu_run <= 1'b1;
                  end else begin
                     r_state    <= S_ERROR;
                     r_load_err <= 1'b1;
                  end
               end
`endif
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.in_ready  = ~r_we;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_waddr;
   assign bus.mem_wdata = r_wdata;
   assign bus.cpu_run   = r_cpu_run;
   assign bus.load_err  = r_load_err;
   assign bus.busy      = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);

endmodule
